button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, the number of consecutive stable cycles required to accept a level change (legal range >=2).
REQ-002 SHALL have parameter REPEAT_DELAY_CYCLES, default 7500000, the cycles from a press pulse to the first auto-repeat pulse (legal range >=2).
REQ-003 SHALL have parameter REPEAT_RATE_CYCLES, default 2500000, the cycles between subsequent auto-repeat pulses (legal range >=2).
REQ-004 SHALL have parameter REPEAT_MASK, 4 bits, default 4'b0110, where a set bit enables auto-repeat for that button.
REQ-005 SHALL have ports: clk  input  1  single clock; all state is in this domain.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 btn_d, btn_l, btn_r, btn_u  input  1 each  raw asynchronous button levels, 1 = pressed.
REQ-008 btn_level  output  4  debounced levels; bit0=d, bit1=l, bit2=r, bit3=u (same order on all vectors).
REQ-009 btn_press  output  4  one-cycle pulse on each debounced 0->1 transition.
REQ-010 btn_release  output  4  one-cycle pulse on each debounced 1->0 transition.
REQ-011 btn_repeat  output  4  one-cycle pulse at press and at each auto-repeat interval, for masked bits only.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer; the second-stage output is the sample s.
REQ-013 Each button SHALL have an independent debounce counter, wide enough for DEBOUNCE_CYCLES-1.
REQ-014 Debounce, per cycle: s==level -> counter<=0; else counter==DEBOUNCE_CYCLES-1 -> level<=s, counter<=0; else counter<=counter+1.
REQ-015 A raw change held stable SHALL appear on btn_level exactly DEBOUNCE_CYCLES+2 cycles after the first clk edge that samples it.
REQ-016 Any mismatch shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no level change and no pulse.
REQ-017 btn_press and btn_release SHALL be registered and asserted in the same cycle btn_level first shows the new value, for exactly one cycle.
REQ-018 Each masked button SHALL have a repeat FSM with states IDLE, DELAY and REPEAT and a counter wide enough for max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)-1.
REQ-019 IDLE: on a press (level going 1), assert btn_repeat together with btn_press, clear the counter, and go to DELAY.
REQ-020 DELAY: level 0 -> IDLE; counter==REPEAT_DELAY_CYCLES-1 -> pulse btn_repeat, clear the counter, go to REPEAT; otherwise increment.
REQ-021 REPEAT: level 0 -> IDLE; counter==REPEAT_RATE_CYCLES-1 -> pulse btn_repeat and clear the counter; otherwise increment.
REQ-022 The first auto-repeat pulse SHALL occur REPEAT_DELAY_CYCLES cycles after the press pulse; later pulses SHALL be spaced by REPEAT_RATE_CYCLES.
REQ-023 btn_repeat SHALL never be asserted in a cycle where the same btn_level bit is 0; a release coinciding with a repeat expiry suppresses that repeat.
REQ-024 For unmasked bits, btn_repeat SHALL be constant 0.
REQ-025 Simultaneous activity on several buttons SHALL be handled independently, with no priority or interaction.

Reset
REQ-026 While rst=1, all synchronizer flops, counters, btn_level, btn_press, btn_release and btn_repeat SHALL be 0, and all repeat FSMs SHALL be in IDLE.
REQ-027 Reset asserted mid-operation SHALL clear state immediately with no pulse emitted.
REQ-028 A button held through reset release SHALL be treated as a fresh press: btn_press (and btn_repeat if masked) DEBOUNCE_CYCLES+2 cycles after release.

Verification (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=5, default mask)
REQ-029 Scenario: btn_u rises and stays high, first sampled at edge 0 -> btn_level[3]=1 and btn_press[3] pulse at edge 6, with btn_repeat[3]=0 throughout.
REQ-030 Scenario: btn_d high for 3 cycles, then low -> btn_level[0] stays 0, with no press or release pulses.
REQ-031 Scenario: btn_l held for 40 cycles after press at cycle P -> btn_repeat[1] at P, P+10, P+15, P+20, ...; btn_release[1] follows 6 cycles after btn_l falls.
REQ-032 Scenario: btn_r released so its debounced fall lands on a repeat-expiry edge -> btn_release[2]=1 and btn_repeat[2]=0 in that cycle.
REQ-033 Scenario: rst pulsed while btn_l is in REPEAT with btn_l held -> all outputs 0 during reset; after release, a press pulse and a repeat pulse at 6 cycles.
REQ-034 Scenario: all four buttons toggled with offset timing -> each bit matches an independent single-button reference model cycle-for-cycle.

Source files
------------

// File: rtl/button_conditioner.sv
// Four-button front end: 2-flop synchronizer, per-button debounce, edge pulses
// and optional auto-repeat on the masked buttons.
module button_conditioner #(
    parameter int          DEBOUNCE_CYCLES     = 250000,
    parameter int          REPEAT_DELAY_CYCLES = 7500000,
    parameter int          REPEAT_RATE_CYCLES  = 2500000,
    parameter logic [3:0]  REPEAT_MASK         = 4'b0110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic [3:0] btn_repeat
);

    // state  | meaning
    // IDLE   | button up, waiting for a press
    // DELAY  | held, counting down to the first auto-repeat
    // REPEAT | held, emitting pulses at the repeat rate
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RW   = $clog2(RMAX);

    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_MAX = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RATE_MAX  = RW'(REPEAT_RATE_CYCLES - 1);

    logic [3:0] raw;
    assign raw = {btn_u, btn_r, btn_l, btn_d};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic          sync1;
        logic          sync2;
        logic          level_int;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic [DW-1:0] db_cnt;

        // level_int is the debounced decision; level_q is its registered copy
        // so the level and its edge pulses leave the block on the same edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1     <= 1'b0;
                sync2     <= 1'b0;
                level_int <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                db_cnt    <= '0;
            end else begin
                sync1 <= raw[i];
                sync2 <= sync1;
                if (sync2 == level_int) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_MAX) begin
                    level_int <= sync2;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
                level_q   <= level_int;
                press_q   <= level_int & ~level_q;
                release_q <= ~level_int & level_q;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;

        if (REPEAT_MASK[i]) begin : g_rep
            rep_state_t    state;
            rep_state_t    state_nxt;
            logic [RW-1:0] cnt;
            logic [RW-1:0] cnt_nxt;
            logic          rep_nxt;
            logic          rep_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state <= IDLE;
                    cnt   <= '0;
                    rep_q <= 1'b0;
                end else begin
                    state <= state_nxt;
                    cnt   <= cnt_nxt;
                    rep_q <= rep_nxt;
                end
            end

            // Decisions use level_int, i.e. the value btn_level takes on this
            // edge, so a coinciding release always wins over a repeat expiry.
            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                rep_nxt   = 1'b0;
                case (state)
                    IDLE: begin
                        if (level_int && !level_q) begin
                            rep_nxt   = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = DELAY;
                        end
                    end
                    DELAY: begin
                        if (!level_int) begin
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else if (cnt == DELAY_MAX) begin
                            rep_nxt   = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = REPEAT;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!level_int) begin
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else if (cnt == RATE_MAX) begin
                            rep_nxt = 1'b1;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    default: begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                endcase
            end

            assign btn_repeat[i] = rep_q;
        end else begin : g_no_rep
            assign btn_repeat[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: cycle scoreboard against a timing model,
// a segment vector table, directed corner sequences and a random phase.
module tb_button_conditioner;

    localparam int         D    = 4;
    localparam int         DLY  = 10;
    localparam int         RATE = 5;
    localparam logic [3:0] MASK = 4'b0110;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_d, btn_l, btn_r, btn_u;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES    (D),
        .REPEAT_DELAY_CYCLES(DLY),
        .REPEAT_RATE_CYCLES (RATE),
        .REPEAT_MASK        (MASK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_d      (btn_d),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .btn_u      (btn_u),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Vectors are packed {repeat, release, press, level}.
    logic [15:0] exp_q[$];
    logic [15:0] obs[$];

    // Timing model: a button's debounced level flips on the D-th consecutive
    // edge whose synchronized sample disagrees with it, and reaches the
    // outputs one edge later; repeats are tracked as absolute deadlines.
    int   cyc = 0;
    logic m_s1[4], m_s2[4], m_lvl[4], m_out[4];
    int   m_run[4];
    int   m_next[4];

    function automatic logic [15:0] dut_vec();
        return {btn_repeat, btn_release, btn_press, btn_level};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {15'h0, act}, {15'h0, exp});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lvl[i] = 1'b0; m_out[i] = 1'b0;
            m_run[i] = 0; m_next[i] = -1;
        end
    endtask

    task automatic model_edge(input logic [3:0] raw, output logic [15:0] e);
        logic old_s2, new_out, pr, rl, rp;
        cyc++;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            old_s2  = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
            new_out = m_lvl[i];
            pr = new_out & ~m_out[i];
            rl = ~new_out & m_out[i];
            if (old_s2 != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_lvl[i] = old_s2;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_out[i] = new_out;
            rp = 1'b0;
            if (MASK[i]) begin
                if (pr) begin
                    rp = 1'b1;
                    m_next[i] = cyc + DLY;
                end else if (new_out && m_next[i] == cyc) begin
                    rp = 1'b1;
                    m_next[i] = cyc + RATE;
                end
                if (!new_out) m_next[i] = -1;
            end
            e[i] = new_out; e[4+i] = pr; e[8+i] = rl; e[12+i] = rp;
        end
    endtask

    // Drives at the falling edge, lets one rising edge pass, samples at the
    // next falling edge and scores the result.
    task automatic step(input logic [3:0] raw, input logic r);
        logic [15:0] e, a;
        logic        rise;
        rise = r && !rst;
        {btn_u, btn_r, btn_l, btn_d} = raw;
        rst = r;
        if (rise) begin
            #1;
            chk("rst_async_clear", dut_vec(), 16'h0);
        end
        if (r) begin
            model_reset();
            e = '0;
        end else begin
            model_edge(raw, e);
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        a = dut_vec();
        obs.push_back(a);
        e = exp_q.pop_front();
        chk($sformatf("sb_cycle_%0d", cyc), a, e);
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        obs.delete();
    endtask

    typedef struct {
        logic [3:0] raw;
        int         len;
        bit         chk_en;
        logic [3:0] lvl;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic       any;
        int         nrep;
        logic [3:0] cur;
        int         hold[4];

        vt[0] = '{4'b0001, 8,  1'b1, 4'b0001};
        vt[1] = '{4'b0011, 8,  1'b1, 4'b0011};
        vt[2] = '{4'b0111, 2,  1'b0, 4'b0000};
        vt[3] = '{4'b0011, 8,  1'b1, 4'b0011};
        vt[4] = '{4'b1010, 9,  1'b1, 4'b1010};
        vt[5] = '{4'b1110, 3,  1'b0, 4'b0000};
        vt[6] = '{4'b0100, 10, 1'b1, 4'b0100};
        vt[7] = '{4'b1111, 7,  1'b1, 4'b1111};
        vt[8] = '{4'b0000, 12, 1'b1, 4'b0000};

        rst = 1'b1;
        {btn_u, btn_r, btn_l, btn_d} = 4'b0000;
        model_reset();
        @(negedge clk);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("reset_state", dut_vec(), 16'h0);
        step(4'b1111, 1'b1);
        chk("reset_state_inputs_high", dut_vec(), 16'h0);
        do_reset();

        // btn_u: press at edge 6, never repeats (unmasked).
        for (int k = 0; k < 12; k++) step(4'b1000, 1'b0);
        for (int k = 0; k < 10; k++) step(4'b0000, 1'b0);
        chk1("u_level_e5", obs[5][3], 1'b0);
        chk1("u_level_e6", obs[6][3], 1'b1);
        chk1("u_press_e6", obs[6][7], 1'b1);
        chk1("u_press_e7", obs[7][7], 1'b0);
        chk1("u_release_e17", obs[17][11], 1'b0);
        chk1("u_release_e18", obs[18][11], 1'b1);
        any = 1'b0;
        foreach (obs[j]) any |= obs[j][15];
        chk1("u_no_repeat", any, 1'b0);
        do_reset();

        // btn_d 3-cycle glitch is rejected.
        for (int k = 0; k < 3; k++) step(4'b0001, 1'b0);
        for (int k = 0; k < 10; k++) step(4'b0000, 1'b0);
        any = 1'b0;
        foreach (obs[j]) any |= obs[j][0] | obs[j][4] | obs[j][8];
        chk1("d_glitch_ignored", any, 1'b0);
        do_reset();

        // btn_l held 50 cycles: repeats at 6,16,21..51; release at 56 masks repeat.
        for (int k = 0; k < 50; k++) step(4'b0010, 1'b0);
        for (int k = 0; k < 10; k++) step(4'b0000, 1'b0);
        chk1("l_press_e6", obs[6][5], 1'b1);
        chk1("l_repeat_e6", obs[6][13], 1'b1);
        chk1("l_repeat_e15", obs[15][13], 1'b0);
        chk1("l_repeat_e16", obs[16][13], 1'b1);
        chk1("l_repeat_e21", obs[21][13], 1'b1);
        chk1("l_repeat_e51", obs[51][13], 1'b1);
        chk1("l_release_e56", obs[56][9], 1'b1);
        chk1("l_repeat_e56", obs[56][13], 1'b0);
        nrep = 0;
        foreach (obs[j]) nrep += int'(obs[j][13]);
        chk("l_repeat_count", 16'(nrep), 16'd9);
        do_reset();

        // btn_r released so the fall lands on the repeat expiry at edge 26.
        for (int k = 0; k < 20; k++) step(4'b0100, 1'b0);
        for (int k = 0; k < 10; k++) step(4'b0000, 1'b0);
        chk1("r_repeat_e21", obs[21][14], 1'b1);
        chk1("r_release_e26", obs[26][10], 1'b1);
        chk1("r_level_e26", obs[26][2], 1'b0);
        chk1("r_repeat_e26", obs[26][14], 1'b0);
        do_reset();

        // Reset while btn_l is in REPEAT and held, then a fresh press.
        for (int k = 0; k < 20; k++) step(4'b0010, 1'b0);
        chk1("l_in_repeat_e16", obs[16][13], 1'b1);
        for (int k = 0; k < 3; k++) step(4'b0010, 1'b1);
        for (int k = 20; k < 23; k++) chk($sformatf("rst_hold_out_%0d", k), obs[k], 16'h0);
        obs.delete();
        for (int k = 0; k < 20; k++) step(4'b0010, 1'b0);
        chk1("post_rst_press_e5", obs[5][5], 1'b0);
        chk1("post_rst_press_e6", obs[6][5], 1'b1);
        chk1("post_rst_repeat_e6", obs[6][13], 1'b1);
        chk1("post_rst_repeat_e16", obs[16][13], 1'b1);
        do_reset();

        // Segment table: several buttons changing together with glitches.
        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < vt[v].len; k++) step(vt[v].raw, 1'b0);
            if (vt[v].chk_en)
                chk($sformatf("vec%0d_level", v), {12'h0, btn_level}, {12'h0, vt[v].lvl});
        end
        do_reset();

        // Independent random hold times on all four buttons.
        cur = 4'b0000;
        for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 14);
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    cur[i]  = ~cur[i];
                    hold[i] = $urandom_range(1, 24);
                end else begin
                    hold[i]--;
                end
            end
            step(cur, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
